// File: rtl/mdu_pkg.sv
// mdu_pkg: shared opcode encoding, default latencies and FSM state type for the MDU.
package mdu_pkg;
    localparam int OP_W = 4;
    localparam logic [OP_W-1:0] MDU_NONE  = 4'd0;
    localparam logic [OP_W-1:0] MDU_MULT  = 4'd1;
    localparam logic [OP_W-1:0] MDU_MULTU = 4'd2;
    localparam logic [OP_W-1:0] MDU_DIV   = 4'd3;
    localparam logic [OP_W-1:0] MDU_DIVU  = 4'd4;
    localparam logic [OP_W-1:0] MDU_MFHI  = 4'd5;
    localparam logic [OP_W-1:0] MDU_MFLO  = 4'd6;
    localparam logic [OP_W-1:0] MDU_MTHI  = 4'd7;
    localparam logic [OP_W-1:0] MDU_MTLO  = 4'd8;
    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;
    typedef enum logic {IDLE, BUSY} state_t;
endpackage

// File: rtl/mdu_calc.sv
// mdu_calc: combinational multiply/divide datapath producing the HI/LO pair for an MDU op.
module mdu_calc
    import mdu_pkg::*;
(
    input  logic [OP_W-1:0] op,
    input  logic [31:0]     a,
    input  logic [31:0]     b,
    output logic [31:0]     res_hi,
    output logic [31:0]     res_lo,
    output logic            div_by_zero
);
    logic [63:0] prod_u, prod_s;
    logic [31:0] abs_a, abs_b, dvs_u, dvs_s, q_u, r_u, q_m, r_m, q_s, r_s;
    assign prod_u = {32'b0, a} * {32'b0, b};
    assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    // Signed division works on magnitudes; 0x80000000 has magnitude 0x80000000 unsigned,
    // so the most-negative / -1 case falls out as 0x80000000 with remainder 0.
    assign abs_a = a[31] ? -a : a;
    assign abs_b = b[31] ? -b : b;
    assign dvs_u = (b == 32'd0) ? 32'd1 : b;
    assign dvs_s = (abs_b == 32'd0) ? 32'd1 : abs_b;
    assign q_u = a / dvs_u;
    assign r_u = a % dvs_u;
    assign q_m = abs_a / dvs_s;
    assign r_m = abs_a % dvs_s;
    assign q_s = (a[31] ^ b[31]) ? -q_m : q_m;
    assign r_s = a[31] ? -r_m : r_m;
    assign div_by_zero = (op == MDU_DIV || op == MDU_DIVU) && b == 32'd0;
    always_comb begin
        res_hi = (op == MDU_MULT)  ? prod_s[63:32] :
                 (op == MDU_MULTU) ? prod_u[63:32] :
                 (op == MDU_DIV)   ? r_s :
                 (op == MDU_DIVU)  ? r_u : 32'd0;
        res_lo = (op == MDU_MULT)  ? prod_s[31:0] :
                 (op == MDU_MULTU) ? prod_u[31:0] :
                 (op == MDU_DIV)   ? q_s :
                 (op == MDU_DIVU)  ? q_u : 32'd0;
    end
endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: fixed-latency MDU sequencer owning HI/LO and raising D-stage stalls.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OP_W-1:0] mdu_op_e,
    input  logic [31:0]     a_e,
    input  logic [31:0]     b_e,
    input  logic [OP_W-1:0] mdu_op_d,
    output logic            busy,
    output logic            stall_md,
    output logic [31:0]     hi,
    output logic [31:0]     lo,
    output logic [31:0]     rd_data
);
    localparam int CW = $clog2(DIV_CYCLES + 1);
    state_t state, state_n;
    logic [CW-1:0] cnt;
    logic [31:0] pend_hi, pend_lo, res_hi, res_lo;
    logic pend_dz, res_dz, start, commit, is_mul;

    mdu_calc u_calc (
        .op          (mdu_op_e),
        .a           (a_e),
        .b           (b_e),
        .res_hi      (res_hi),
        .res_lo      (res_lo),
        .div_by_zero (res_dz)
    );

    assign busy    = (state == BUSY);
    assign is_mul  = (mdu_op_e == MDU_MULT) || (mdu_op_e == MDU_MULTU);
    assign start   = (mdu_op_e >= MDU_MULT) && (mdu_op_e <= MDU_DIVU) && !busy;
    assign commit  = busy && (cnt == CW'(1));
    assign stall_md = (start || busy) && (mdu_op_d >= MDU_MULT) && (mdu_op_d <= MDU_MTLO);
    assign rd_data = (mdu_op_e == MDU_MFHI) ? hi : (mdu_op_e == MDU_MFLO) ? lo : 32'd0;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        state_n = start ? BUSY : commit ? IDLE : state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_dz <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            if (start) begin
                cnt     <= is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                pend_hi <= res_hi;
                pend_lo <= res_lo;
                pend_dz <= res_dz;
            end else if (busy) begin
                cnt <= cnt - CW'(1);
            end
            // A zero divisor still occupies the unit but leaves HI/LO untouched.
            if (commit && !pend_dz) begin
                hi <= pend_hi;
                lo <= pend_lo;
            end
            if (!busy && mdu_op_e == MDU_MTHI) hi <= a_e;
            if (!busy && mdu_op_e == MDU_MTLO) lo <= a_e;
        end
    end
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed and randomized checks of mdu_ctrl against a plain-arithmetic HI/LO model.
module tb_mdu_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  mdu_op_e = 4'd0;
    logic [31:0] a_e = 32'd0;
    logic [31:0] b_e = 32'd0;
    logic [3:0]  mdu_op_d = 4'd0;
    logic        busy, stall_md;
    logic [31:0] hi, lo, rd_data;
    int          passed = 0;
    int          total = 0;
    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    mdu_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .mdu_op_e (mdu_op_e),
        .a_e      (a_e),
        .b_e      (b_e),
        .mdu_op_d (mdu_op_d),
        .busy     (busy),
        .stall_md (stall_md),
        .hi       (hi),
        .lo       (lo),
        .rd_data  (rd_data)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Architectural result of one MDU arithmetic op, straight from the ISA definition.
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sp, sq, sr;
        logic [63:0] up;
        if (op == 4'd1) begin
            sp = longint'($signed(a)) * longint'($signed(b));
            exp_hi = 32'(sp >>> 32);
            exp_lo = 32'(sp);
        end else if (op == 4'd2) begin
            up = 64'(a) * 64'(b);
            exp_hi = up[63:32];
            exp_lo = up[31:0];
        end else if (op == 4'd3 && b != 0) begin
            sq = longint'($signed(a)) / longint'($signed(b));
            sr = longint'($signed(a)) % longint'($signed(b));
            exp_lo = 32'(sq);
            exp_hi = 32'(sr);
        end else if (op == 4'd4 && b != 0) begin
            exp_lo = a / b;
            exp_hi = a % b;
        end
    endtask

    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] opd, input string name);
        int          n = (op <= 4'd2) ? 5 : 10;
        logic        d_mdu = (opd >= 4'd1 && opd <= 4'd8);
        logic [31:0] old_hi = exp_hi;
        logic [31:0] old_lo = exp_lo;
        int          errs = 0;
        mdu_op_e = op; a_e = a; b_e = b; mdu_op_d = opd;
        #1;
        total++;
        if (busy !== 1'b0 || stall_md !== d_mdu) begin
            $display("FAIL %s start: busy=%b stall=%b want busy=0 stall=%b", name, busy, stall_md, d_mdu);
        end else passed++;
        model(op, a, b);
        for (int k = 1; k <= n; k++) begin
            step();
            mdu_op_e = 4'd0;
            #1;
            if (busy !== 1'b1 || stall_md !== d_mdu || hi !== old_hi || lo !== old_lo) begin
                if (errs == 0)
                    $display("FAIL %s busy cycle %0d: busy=%b stall=%b hi=%h lo=%h want 1 %b %h %h",
                             name, k, busy, stall_md, hi, lo, d_mdu, old_hi, old_lo);
                errs++;
            end
        end
        total++;
        if (errs == 0) passed++;
        step();
        mdu_op_e = 4'd0;
        #1;
        total++;
        if (busy !== 1'b0 || stall_md !== 1'b0 || hi !== exp_hi || lo !== exp_lo) begin
            $display("FAIL %s done: busy=%b stall=%b hi=%h lo=%h want 0 0 %h %h",
                     name, busy, stall_md, hi, lo, exp_hi, exp_lo);
        end else passed++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        mdu_op_e = 4'd5;
        step();
        step();
        reset = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || stall_md !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || rd_data !== 32'd0) begin
            $display("FAIL reset: busy=%b stall=%b hi=%h lo=%h rd=%h want all 0", busy, stall_md, hi, lo, rd_data);
        end else passed++;
        mdu_op_e = 4'd0;
        exp_hi = 32'd0;
        exp_lo = 32'd0;
    endtask

    task automatic test_mult();
        do_op(4'd1, 32'd3, 32'hFFFF_FFFE, 4'd6, "mult_neg");
        do_op(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd0, "multu_max");
        do_op(4'd1, 32'h8000_0000, 32'h8000_0000, 4'd9, "mult_minmin");
    endtask

    task automatic test_div();
        do_op(4'd4, 32'd7, 32'd2, 4'd1, "divu_7_2");
        do_op(4'd3, 32'hFFFF_FFF9, 32'd2, 4'd0, "div_m7_2");
        do_op(4'd3, 32'd7, 32'hFFFF_FFFE, 4'd8, "div_7_m2");
        do_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 4'd0, "div_ovf");
    endtask

    task automatic test_move();
        mdu_op_e = 4'd7; a_e = 32'h1234_5678; mdu_op_d = 4'd0;
        step();
        mdu_op_e = 4'd5;
        #1;
        total++;
        if (rd_data !== 32'h1234_5678) $display("FAIL mfhi_fwd: rd=%h want 12345678", rd_data);
        else passed++;
        exp_hi = 32'h1234_5678;
        mdu_op_e = 4'd8; a_e = 32'h0BAD_F00D;
        step();
        mdu_op_e = 4'd6;
        #1;
        total++;
        if (rd_data !== 32'h0BAD_F00D || hi !== exp_hi) $display("FAIL mflo_fwd: rd=%h hi=%h want 0badf00d %h", rd_data, hi, exp_hi);
        else passed++;
        exp_lo = 32'h0BAD_F00D;
        mdu_op_e = 4'd0;
        #1;
        total++;
        if (rd_data !== 32'd0) $display("FAIL rd_idle: rd=%h want 0", rd_data);
        else passed++;
    endtask

    task automatic test_div_zero();
        mdu_op_e = 4'd7; a_e = 32'h0000_AAAA;
        step();
        mdu_op_e = 4'd8; a_e = 32'h0000_5555;
        step();
        exp_hi = 32'h0000_AAAA;
        exp_lo = 32'h0000_5555;
        do_op(4'd3, 32'd100, 32'd0, 4'd6, "div_zero");
        do_op(4'd4, 32'd100, 32'd0, 4'd0, "divu_zero");
    endtask

    task automatic test_back_to_back();
        do_op(4'd2, 32'd6, 32'd7, 4'd5, "b2b_first");
        do_op(4'd4, 32'd100, 32'd9, 4'd7, "b2b_second");
    endtask

    task automatic test_busy_ignore();
        logic [31:0] want_hi;
        mdu_op_e = 4'd1; a_e = 32'd11; b_e = 32'd13; mdu_op_d = 4'd0;
        model(4'd1, 32'd11, 32'd13);
        step();
        mdu_op_e = 4'd7; a_e = 32'hDEAD_BEEF;
        step();
        mdu_op_e = 4'd3; a_e = 32'd1; b_e = 32'd1;
        step();
        mdu_op_e = 4'd0;
        repeat (3) step();
        want_hi = exp_hi;
        total++;
        if (busy !== 1'b0 || hi !== want_hi || lo !== exp_lo) $display("FAIL busy_ignore: busy=%b hi=%h lo=%h want 0 %h %h", busy, hi, lo, want_hi, exp_lo);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int errs = 0;
        mdu_op_e = 4'd1; a_e = 32'd1234; b_e = 32'd5678; mdu_op_d = 4'd0;
        step();
        mdu_op_e = 4'd0;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        total++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) $display("FAIL reset_mid: busy=%b hi=%h lo=%h want 0 0 0", busy, hi, lo);
        else passed++;
        for (int k = 0; k < 8; k++) begin
            step();
            if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) errs++;
        end
        total++;
        if (errs != 0) $display("FAIL reset_mid_after: %0d cycles with busy/hi/lo nonzero, want 0", errs);
        else passed++;
    endtask

    task automatic test_random();
        logic [3:0]  op, opd;
        logic [31:0] a, b;
        for (int i = 0; i < 24; i++) begin
            op = 4'($urandom_range(1, 4));
            opd = 4'($urandom_range(0, 15));
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
            if ($urandom_range(0, 3) == 0) a = $signed(a) >>> 20;
            do_op(op, a, b, opd, $sformatf("rand%0d_op%0d", i, op));
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_move();
        test_div_zero();
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
